// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit SRL/SLL/SRA/pass-through shifter, STEP bit positions per cycle.
// Optional macro SHIFT_ZERO_BYPASS_EN: zero-amount and pass-through requests skip SHIFT.
module shift_sequencer #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [1:0]  req_alufn,
  input  logic [4:0]  req_shamt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy
);

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
      $error("shift_sequencer: STEP must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [4:0] STEP5 = 5'(STEP);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_acc;
  logic [31:0] w_acc_next;
  logic [31:0] w_shifted;
  logic [4:0]  r_rem;
  logic [4:0]  w_rem_next;
  logic [4:0]  w_k;
  logic [1:0]  r_op;
  logic [1:0]  w_op_next;

  assign w_k = (r_rem < STEP5) ? r_rem : STEP5;

  // Only 0..STEP constant shifts are ever needed, so this is a small mux, not a barrel shifter.
  always_comb begin
    w_shifted = r_acc;
    for (int j = 1; j <= STEP; j++) begin
      if (w_k == 5'(j)) begin
        unique case (r_op)
          2'b00:   w_shifted = r_acc >> j;
          2'b01:   w_shifted = r_acc << j;
          2'b10:   w_shifted = $signed(r_acc) >>> j;
          default: w_shifted = r_acc;
        endcase
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_acc_next = r_acc;
    w_rem_next = r_rem;
    w_op_next  = r_op;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_acc_next = req_a;
          w_op_next  = req_alufn;
          w_rem_next = (req_alufn == 2'b11) ? 5'd0 : req_shamt;
          w_next     = S_SHIFT;
`ifdef SHIFT_ZERO_BYPASS_EN
          if (req_shamt == 5'd0 || req_alufn == 2'b11) begin
            w_next = S_DONE;
          end
`endif
        end
      end
      S_SHIFT: begin
        w_acc_next = w_shifted;
        w_rem_next = r_rem - w_k;
        if (r_rem == w_k) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_op    <= 2'b00;
    end else begin
      r_state <= w_next;
      r_acc   <= w_acc_next;
      r_rem   <= w_rem_next;
      r_op    <= w_op_next;
    end
  end

  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign rsp_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign rsp_result = rsp_valid ? r_acc : 32'h0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: port 0 runs a STEP=1 instance, port 1 a STEP=4 instance.
// Stimulus pushes expected result/latency; a negedge monitor pops and compares on each response.
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [31:0] reqA [2];
  logic [1:0]  reqAlufn [2];
  logic [4:0]  reqShamt [2];
  logic [1:0]  rspValid;
  logic [1:0]  rspReady;
  logic [31:0] rspResult [2];
  logic [1:0]  busy;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [1:0] inRsp = 2'b00;

  typedef struct {
    int          port;
    logic [31:0] res;
    int          lat;
    int          acceptCyc;
  } expT;

  expT sb[$];

  shift_sequencer #(.STEP(1)) dutStep1 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_a(reqA[0]),
    .req_alufn(reqAlufn[0]), .req_shamt(reqShamt[0]),
    .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]), .rsp_result(rspResult[0]),
    .busy(busy[0])
  );

  shift_sequencer #(.STEP(4)) dutStep4 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_a(reqA[1]),
    .req_alufn(reqAlufn[1]), .req_shamt(reqShamt[1]),
    .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]), .rsp_result(rspResult[1]),
    .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  function automatic int expLat(int step, logic [1:0] fn, logic [4:0] sh);
    int n;
    n = (fn == 2'b11) ? 0 : int'(sh);
`ifdef SHIFT_ZERO_BYPASS_EN
    if (n == 0) return 1;
`endif
    if (n == 0) return 2;
    return 1 + (n + step - 1) / step;
  endfunction

  function automatic int pending(int p);
    int n;
    n = 0;
    foreach (sb[j]) if (sb[j].port == p) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request once the port is ready; the inputs are scrambled right after acceptance.
  task automatic applyStimulus(input int p, input logic [31:0] a, input logic [1:0] fn,
                               input logic [4:0] sh, input logic [31:0] res);
    int n;
    expT e;
    n = 0;
    tick();
    while (!reqReady[p] && n < 200) begin
      tick();
      n++;
    end
    if (!reqReady[p]) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout port%0d: got reqReady=0, want 1", p);
      return;
    end
    reqA[p]     = a;
    reqAlufn[p] = fn;
    reqShamt[p] = sh;
    reqValid[p] = 1'b1;
    e.port      = p;
    e.res       = res;
    e.lat       = expLat((p == 0) ? 1 : 4, fn, sh);
    e.acceptCyc = cycle;
    sb.push_back(e);
    tick();
    reqValid[p] = 1'b0;
    reqA[p]     = 32'hDEADBEEF;
    reqAlufn[p] = 2'b01;
    reqShamt[p] = 5'd3;
  endtask

  task automatic waitIdle(input int p);
    int n;
    n = 0;
    while ((busy[p] || pending(p) != 0) && n < 500) begin
      tick();
      n++;
    end
    checkOutput($sformatf("drain port%0d", p), {31'd0, busy[p]}, 32'd0);
  endtask

  // Pops the oldest expectation for a port when it responds; flags responses nobody asked for.
  always @(negedge clk) begin : monitor
    int idx;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (!rspValid[i]) begin
          inRsp[i] <= 1'b0;
        end else begin
          idx = -1;
          foreach (sb[j]) if (sb[j].port == i && idx < 0) idx = j;
          if (idx < 0) begin
            if (!inRsp[i]) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpectedRsp port%0d: got rsp 0x%08h, want no response", i, rspResult[i]);
            end
            inRsp[i] <= 1'b1;
          end else begin
            if (!inRsp[i]) begin
              checkOutput($sformatf("latency port%0d", i), 32'(cycle - sb[idx].acceptCyc), 32'(sb[idx].lat));
            end
            checkOutput($sformatf("result port%0d", i), rspResult[i], sb[idx].res);
            checkOutput($sformatf("busyInDone port%0d", i), {31'd0, busy[i]}, 32'd1);
            if (rspReady[i]) begin
              sb.delete(idx);
              inRsp[i] <= 1'b0;
            end else begin
              inRsp[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    logic sawValid;
    rst      = 1'b1;
    reqValid = 2'b00;
    rspReady = 2'b11;
    for (int i = 0; i < 2; i++) begin
      reqA[i]     = '0;
      reqAlufn[i] = '0;
      reqShamt[i] = '0;
    end

    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      checkOutput("resetRspValid", {31'd0, rspValid[i]}, 32'd0);
      checkOutput("resetBusy", {31'd0, busy[i]}, 32'd0);
      checkOutput("resetResult", rspResult[i], 32'h0);
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      checkOutput("resetReqReady", {31'd0, reqReady[i]}, 32'd1);
    end

    // SRA with backpressure; stray requests during DONE must be ignored.
    rspReady[0] = 1'b0;
    applyStimulus(0, 32'h80000010, 2'b10, 5'd4, 32'hF8000001);
    n = 0;
    while (!rspValid[0] && n < 50) begin
      tick();
      n++;
    end
    checkOutput("reachDone", {31'd0, rspValid[0]}, 32'd1);
    reqA[0]     = 32'h11111111;
    reqAlufn[0] = 2'b00;
    reqShamt[0] = 5'd1;
    reqValid[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput("heldReqReady", {31'd0, reqReady[0]}, 32'd0);
      checkOutput("heldBusy", {31'd0, busy[0]}, 32'd1);
    end
    reqValid[0] = 1'b0;
    rspReady[0] = 1'b1;
    tick();
    checkOutput("idleAfterHandshake", {31'd0, reqReady[0]}, 32'd1);
    checkOutput("busyAfterHandshake", {31'd0, busy[0]}, 32'd0);

    applyStimulus(0, 32'h80000010, 2'b00, 5'd4, 32'h08000001);
    applyStimulus(0, 32'h00000001, 2'b01, 5'd31, 32'h80000000);
    applyStimulus(0, 32'h80000000, 2'b10, 5'd31, 32'hFFFFFFFF);
    applyStimulus(0, 32'h12345678, 2'b11, 5'd9, 32'h12345678);
    applyStimulus(0, 32'hA5A5A5A5, 2'b00, 5'd0, 32'hA5A5A5A5);

    applyStimulus(1, 32'h00000003, 2'b01, 5'd7, 32'h00000180);
    applyStimulus(1, 32'h80000000, 2'b10, 5'd31, 32'hFFFFFFFF);
    applyStimulus(1, 32'hF0000000, 2'b00, 5'd16, 32'h0000F000);
    applyStimulus(1, 32'h7FFFFFFF, 2'b10, 5'd30, 32'h00000001);
    waitIdle(0);
    waitIdle(1);

    // Reset in the middle of a long SHIFT discards the operation.
    applyStimulus(0, 32'hFFFF0000, 2'b00, 5'd20, 32'h00000FFF);
    repeat (5) tick();
    checkOutput("busyMidShift", {31'd0, busy[0]}, 32'd1);
    rst = 1'b1;
    #2;
    checkOutput("asyncRstBusy", {31'd0, busy[0]}, 32'd0);
    checkOutput("asyncRstValid", {31'd0, rspValid[0]}, 32'd0);
    checkOutput("asyncRstResult", rspResult[0], 32'h0);
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].port == 0) sb.delete(j);
    end
    tick();
    rst = 1'b0;
    sawValid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (rspValid[0]) sawValid = 1'b1;
    end
    checkOutput("noRspAfterRst", {31'd0, sawValid}, 32'd0);
    applyStimulus(0, 32'hFFFFFFFF, 2'b00, 5'd1, 32'h7FFFFFFF);
    waitIdle(0);
    waitIdle(1);
    checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
